// File: rtl/param_reg_file_pkg.sv
// Shared defaults for the pipeline register-file slice.
// Holds the default widths and a width helper for the pending counter.
package param_reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // The pending count must reach 2**addr_w, so it needs one bit more than an index.
  function automatic int cnt_w(int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Read, writeback, issue and flush signals of the register file.
// Read ports are packed side by side; port i sits at [i*W +: W].
interface param_reg_file_if
  import param_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic [ADDR_W:0]          pending_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, pending_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, pending_cnt
  );

endinterface

// File: rtl/param_reg_file_reg_scoreboard.sv
// Per-register pending bits with flush > alloc > writeback-clear priority.
// Pending vector and its popcount both update on the same clock edge.
module reg_scoreboard
  import param_reg_file_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [ADDR_W:0]       pending_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    pending_nxt = pending;
    cnt_nxt     = '0;
    if (flush) begin
      pending_nxt = '0;
    end else begin
      // Clear before set so a same-cycle alloc of the written register wins.
      if (wr_en)    pending_nxt[wr_addr]    = 1'b0;
      if (alloc_en) pending_nxt[alloc_addr] = 1'b1;
    end
    if (ZERO_R0 != 0) pending_nxt[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Multi-port register file with write-through bypass and RAW pending tracking.
// Reads are combinational (0 cycles); writes and pending updates take effect at the clock edge.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              reset,
  param_reg_file_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]           pending;
  logic [cnt_w(ADDR_W)-1:0]   cnt;
  logic                       wr_ok;
  logic [DATA_W-1:0]          rd_val [NUM_RD];
  logic                       rd_bsy [NUM_RD];

  assign wr_ok = bus.wr_en && !((ZERO_R0 != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .alloc_en    (bus.alloc_en),
    .alloc_addr  (bus.alloc_addr),
    .flush       (bus.flush),
    .pending     (pending),
    .pending_cnt (cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              byp;

    assign ra      = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_R0 != 0) && (ra == '0);
    assign byp     = (BYPASS != 0) && wr_ok && (bus.wr_addr == ra);
    // Reset also masks the bypass path so nothing leaks through while held in reset.
    assign rd_val[i] = (!reset || is_zero) ? '0 : (byp ? bus.wr_data : regs[ra]);
    assign rd_bsy[i] = !is_zero && !byp && pending[ra];
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*DATA_W +: DATA_W] = rd_val[i];
      bus.rd_busy[i]                  = rd_bsy[i];
    end
  end

  assign bus.pending_cnt = cnt;

endmodule
